instr_fetch_responder: RTL and testbench
========================================

INSTR_FETCH_RESPONDER -- requirements
Module: instr_fetch_responder

Interface
REQ-001 Parameter ADDR_BITS, default 8, SHALL set the word-index width: memory depth 2^ADDR_BITS 32-bit words.
REQ-002 Parameter WAIT_CYCLES, default 2, range 0..15, SHALL set the wait states added before each response.
REQ-003 Clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-004 Reset  input  1  SHALL be the synchronous, active-low reset (0 = reset, sampled on the Clk rising edge).
REQ-005 ReqValid  input  1  SHALL indicate that a fetch request is present on ReqAddress.
REQ-006 ReqAddress  input  32  SHALL carry the byte address of the fetch (the PC value).
REQ-007 ReqReady  output  1  SHALL indicate that a request can be accepted this cycle.
REQ-008 RespValid  output  1  SHALL indicate that RespInstruction/RespError are valid.
REQ-009 RespInstruction  output  32  SHALL carry the fetched word.
REQ-010 RespError  output  1  SHALL flag a misaligned or out-of-range fetch.
REQ-011 RespReady  input  1  SHALL indicate that the consumer takes the response this cycle.
REQ-012 Busy  output  1  SHALL be high while a transaction is outstanding; the PC stage uses ~Busy as PCWrite.
REQ-013 LoadEn  input  1  SHALL enable a memory write this cycle.
REQ-014 LoadAddress  input  ADDR_BITS  SHALL give the word index for the write.
REQ-015 LoadData  input  32  SHALL give the write data.

Function
REQ-016 States SHALL be IDLE, WAIT, RESP; Busy = (state != IDLE); ReqReady = (state == IDLE); RespValid = (state == RESP).
REQ-017 IDLE: when ReqValid=1 at an edge, the block SHALL capture ReqAddress, load the wait counter with WAIT_CYCLES and enter WAIT; otherwise it stays in IDLE.
REQ-018 WAIT: a nonzero counter SHALL decrement by 1 per edge; at counter 0 the block SHALL register the response and enter RESP on that edge.
REQ-019 Latency: RespValid SHALL rise exactly WAIT_CYCLES+1 edges after the accepting edge.
REQ-020 Word index SHALL be captured ReqAddress[ADDR_BITS+1:2].
REQ-021 RespError SHALL be 1 if ReqAddress[1:0] != 0 or any of ReqAddress[31:ADDR_BITS+2] is 1; RespInstruction SHALL then be 32'h0.
REQ-022 RESP: RespInstruction and RespError SHALL hold stable until RespValid&RespReady; on that edge the block SHALL return to IDLE.
REQ-023 No request SHALL be accepted in the cycle of a response handshake; back-to-back fetches therefore cost one IDLE cycle.
REQ-024 LoadEn SHALL write LoadData to LoadAddress on the edge in any state, including reset.
REQ-025 A write to the word being read on the same edge as the WAIT-to-RESP transition SHALL NOT affect that response (read-before-write).
REQ-026 ReqAddress and ReqValid changes outside IDLE SHALL be ignored.

Reset
REQ-027 With Reset=0 at an edge, the state SHALL become IDLE and the counter 0; RespInstruction=32'h0, RespError=0, RespValid=0, Busy=0, ReqReady=1.
REQ-028 Reset during WAIT or RESP SHALL abandon the transaction with no response.
REQ-029 Reset SHALL NOT clear memory contents.

Verification (ADDR_BITS=8, WAIT_CYCLES=2 unless stated)
REQ-030 Load word 3 = 32'h8C220004, then request 32'h0000000C with RespReady=1 -> RespValid high 3 edges after accept with 32'h8C220004 and RespError=0; Busy high for 3 cycles plus the RESP cycle.
REQ-031 Hold RespReady=0 for 5 cycles in RESP -> outputs stable and ReqReady=0; raise RespReady -> IDLE on the next edge.
REQ-032 Request 32'h00000006, then 32'h00000400 -> each returns RespError=1 and RespInstruction=32'h0.
REQ-033 Drive Reset=0 for one edge mid-WAIT -> IDLE with RespValid=0 and ReqReady=1; a refetch of 32'h0000000C still returns 32'h8C220004.
REQ-034 LoadEn to word 3 with 32'h00000000 on the final WAIT edge -> the response is 32'h8C220004; the next fetch of 32'h0000000C returns 32'h00000000.
REQ-035 WAIT_CYCLES=0 -> RespValid rises 1 edge after accept.

Source files
------------

// File: rtl/instr_fetch_responder_if.sv
// Bus bundle between an instruction-fetch stage and the fetch responder.
//   Request : req_valid, req_address (byte PC), req_ready
//   Response: resp_valid, resp_instruction, resp_error, resp_ready
//   Status  : busy (the PC stage uses ~busy as its PC write enable)
//   Loader  : load_en, load_address (word index), load_data
// The master modport is the fetch stage and loader side.
// The slave modport is the responder side.
interface instr_fetch_responder_if #(
    parameter int unsigned ADDR_BITS = 8
);
    logic                 req_valid;
    logic [31:0]          req_address;
    logic                 req_ready;
    logic                 resp_valid;
    logic [31:0]          resp_instruction;
    logic                 resp_error;
    logic                 resp_ready;
    logic                 busy;
    logic                 load_en;
    logic [ADDR_BITS-1:0] load_address;
    logic [31:0]          load_data;

    modport master (
        output req_valid, req_address, resp_ready,
        output load_en, load_address, load_data,
        input  req_ready, resp_valid, resp_instruction, resp_error, busy
    );

    modport slave (
        input  req_valid, req_address, resp_ready,
        input  load_en, load_address, load_data,
        output req_ready, resp_valid, resp_instruction, resp_error, busy
    );
endinterface

// File: rtl/instr_fetch_responder.sv
// Instruction fetch responder.
// It holds a word-addressed instruction memory of 2^ADDR_BITS 32-bit words.
// It answers one fetch at a time, after WAIT_CYCLES wait states.
// Ports:
//   clk_i   : single clock, rising edge
//   rst_ni  : synchronous active-low reset; the memory contents are kept
//   fetch_io: request/response handshake, busy status and memory load port
// The response is registered on the WAIT->RESP edge.
// It holds until it is taken with resp_valid & resp_ready.
module instr_fetch_responder #(
    parameter int unsigned ADDR_BITS   = 8,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    instr_fetch_responder_if.slave fetch_io
);

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [ADDR_BITS-1:0] idx_q, idx_d;
    logic                 err_q, err_d;
    logic [31:0]          instr_q, instr_d;
    logic                 rerr_q, rerr_d;

    logic [31:0]          mem_q [0:(1 << ADDR_BITS)-1];

    // Memory write port; it is deliberately not gated by reset or by state.
    always_ff @(posedge clk_i) begin
        if (fetch_io.load_en) begin
            mem_q[fetch_io.load_address] <= fetch_io.load_data;
        end
    end

    // Next-state and datapath decode for the fetch transaction.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        err_d   = err_q;
        instr_d = instr_q;
        rerr_d  = rerr_q;
        case (state_q)
            ST_IDLE: begin
                if (fetch_io.req_valid) begin
                    state_d = ST_WAIT;
                    cnt_d   = WAIT_LOAD;
                    idx_d   = fetch_io.req_address[ADDR_BITS+1:2];
                    // Misaligned, or address bits beyond the memory are set.
                    err_d   = (fetch_io.req_address[1:0] != 2'b00) ||
                              ((fetch_io.req_address >> (ADDR_BITS + 2)) != 32'h0);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // mem_q still holds the pre-edge value here.
                    // A write on this same edge is therefore not seen (read-before-write).
                    state_d = ST_RESP;
                    instr_d = err_q ? 32'h0 : mem_q[idx_q];
                    rerr_d  = err_q;
                end
            end
            ST_RESP: begin
                if (fetch_io.resp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and response registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            instr_q <= 32'h0;
            rerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            instr_q <= instr_d;
            rerr_q  <= rerr_d;
        end
    end

    assign fetch_io.req_ready        = (state_q == ST_IDLE);
    assign fetch_io.busy             = (state_q != ST_IDLE);
    assign fetch_io.resp_valid       = (state_q == ST_RESP);
    assign fetch_io.resp_instruction = instr_q;
    assign fetch_io.resp_error       = rerr_q;

endmodule

// File: tb/tb_instr_fetch_responder.sv
// Directed bench for instr_fetch_responder.
// Main instance: ADDR_BITS=8, WAIT_CYCLES=2.
// Second instance: WAIT_CYCLES=0.
module tb_instr_fetch_responder;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    instr_fetch_responder_if #(.ADDR_BITS(8)) bus ();
    instr_fetch_responder_if #(.ADDR_BITS(8)) bus0 ();

    instr_fetch_responder #(.ADDR_BITS(8), .WAIT_CYCLES(2)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .fetch_io (bus)
    );

    instr_fetch_responder #(.ADDR_BITS(8), .WAIT_CYCLES(0)) dut0 (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .fetch_io (bus0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge; the bench then samples and drives 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [7:0] a, input logic [31:0] d);
        bus.load_en = 1'b1; bus.load_address = a; bus.load_data = d;
        tick();
        bus.load_en = 1'b0;
    endtask

    // Present a request for one edge; on return the DUT has accepted it.
    task automatic accept(input logic [31:0] addr);
        bus.req_valid = 1'b1; bus.req_address = addr;
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        checks++;
        if (bus.resp_valid !== 1'b0 || bus.busy !== 1'b0 || bus.req_ready !== 1'b1 ||
            bus.resp_instruction !== 32'h0 || bus.resp_error !== 1'b0) begin
            errors++;
            $display("FAIL reset: rv=%b busy=%b rr=%b instr=%h err=%b required 0 0 1 00000000 0",
                     bus.resp_valid, bus.busy, bus.req_ready, bus.resp_instruction, bus.resp_error);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int n;
        load_word(8'd3, 32'h8C220004);
        bus.resp_ready = 1'b1;
        accept(32'h0000000C);
        checks++;
        if (bus.busy !== 1'b1 || bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL accept_state: busy=%b rr=%b rv=%b required 1 0 0",
                     bus.busy, bus.req_ready, bus.resp_valid);
        end
        n = 1;
        while (bus.resp_valid !== 1'b1 && n < 10) begin
            tick();
            if (bus.resp_valid !== 1'b1) begin
                checks++;
                if (bus.busy !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_wait: busy=%b required 1", bus.busy);
                end
            end
            n++;
        end
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL latency: edges=%0d required 3", n - 1);
        end
        checks++;
        if (bus.resp_instruction !== 32'h8C220004 || bus.resp_error !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_data: instr=%h err=%b busy=%b required 8c220004 0 1",
                     bus.resp_instruction, bus.resp_error, bus.busy);
        end
        tick();
        checks++;
        if (bus.resp_valid !== 1'b0 || bus.busy !== 1'b0 || bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_done: rv=%b busy=%b rr=%b required 0 0 1",
                     bus.resp_valid, bus.busy, bus.req_ready);
        end
    endtask

    task automatic test_hold();
        bus.resp_ready = 1'b0;
        accept(32'h0000000C);
        tick(); tick(); tick();
        for (int i = 0; i < 5; i++) begin
            // Request-side activity while not idle must be ignored.
            bus.req_valid = 1'b1;
            bus.req_address = 32'h00000010 + 32'(i);
            checks++;
            if (bus.resp_valid !== 1'b1 || bus.req_ready !== 1'b0 ||
                bus.resp_instruction !== 32'h8C220004 || bus.resp_error !== 1'b0) begin
                errors++;
                $display("FAIL hold_%0d: rv=%b rr=%b instr=%h err=%b required 1 0 8c220004 0",
                         i, bus.resp_valid, bus.req_ready, bus.resp_instruction, bus.resp_error);
            end
            tick();
        end
        bus.req_valid = 1'b0;
        bus.resp_ready = 1'b1;
        tick();
        checks++;
        if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_release: rv=%b rr=%b required 0 1", bus.resp_valid, bus.req_ready);
        end
    endtask

    task automatic test_error();
        logic [31:0] addrs [2];
        addrs[0] = 32'h00000006;
        addrs[1] = 32'h00000400;
        bus.resp_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            accept(addrs[i]);
            tick(); tick(); tick();
            checks++;
            if (bus.resp_valid !== 1'b1 || bus.resp_error !== 1'b1 || bus.resp_instruction !== 32'h0) begin
                errors++;
                $display("FAIL error_%h: rv=%b err=%b instr=%h required 1 1 00000000",
                         addrs[i], bus.resp_valid, bus.resp_error, bus.resp_instruction);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_wait();
        int seen;
        bus.resp_ready = 1'b1;
        accept(32'h0000000C);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: rv=%b rr=%b busy=%b required 0 1 0",
                     bus.resp_valid, bus.req_ready, bus.busy);
        end
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.resp_valid === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL reset_abandon: responses=%0d required 0", seen);
        end
        accept(32'h0000000C);
        tick(); tick(); tick();
        checks++;
        if (bus.resp_valid !== 1'b1 || bus.resp_instruction !== 32'h8C220004) begin
            errors++;
            $display("FAIL refetch: rv=%b instr=%h required 1 8c220004",
                     bus.resp_valid, bus.resp_instruction);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        bus.resp_ready = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_address = 32'h0000000C;
        tick(); tick(); tick(); tick();
        checks++;
        if (bus.resp_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first: rv=%b required 1", bus.resp_valid);
        end
        tick();
        checks++;
        if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap: rr=%b busy=%b required 1 0", bus.req_ready, bus.busy);
        end
        tick();
        bus.req_valid = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second_accept: busy=%b required 1", bus.busy);
        end
        tick(); tick(); tick();
        checks++;
        if (bus.resp_valid !== 1'b1 || bus.resp_instruction !== 32'h8C220004) begin
            errors++;
            $display("FAIL b2b_second: rv=%b instr=%h required 1 8c220004",
                     bus.resp_valid, bus.resp_instruction);
        end
        tick();
    endtask

    task automatic test_read_before_write();
        bus.resp_ready = 1'b0;
        accept(32'h0000000C);
        tick(); tick();
        // The next edge is the WAIT->RESP edge; overwrite the same word on it.
        bus.load_en = 1'b1; bus.load_address = 8'd3; bus.load_data = 32'h00000000;
        tick();
        bus.load_en = 1'b0;
        checks++;
        if (bus.resp_valid !== 1'b1 || bus.resp_instruction !== 32'h8C220004) begin
            errors++;
            $display("FAIL rbw_old: rv=%b instr=%h required 1 8c220004",
                     bus.resp_valid, bus.resp_instruction);
        end
        bus.resp_ready = 1'b1;
        tick();
        accept(32'h0000000C);
        tick(); tick(); tick();
        checks++;
        if (bus.resp_valid !== 1'b1 || bus.resp_instruction !== 32'h00000000) begin
            errors++;
            $display("FAIL rbw_new: rv=%b instr=%h required 1 00000000",
                     bus.resp_valid, bus.resp_instruction);
        end
        tick();
    endtask

    task automatic test_wait0();
        bus0.load_en = 1'b1; bus0.load_address = 8'd5; bus0.load_data = 32'h12345678;
        tick();
        bus0.load_en = 1'b0;
        bus0.resp_ready = 1'b1;
        bus0.req_valid = 1'b1; bus0.req_address = 32'h00000014;
        tick();
        bus0.req_valid = 1'b0;
        checks++;
        if (bus0.resp_valid !== 1'b0 || bus0.busy !== 1'b1) begin
            errors++;
            $display("FAIL wait0_accept: rv=%b busy=%b required 0 1", bus0.resp_valid, bus0.busy);
        end
        tick();
        checks++;
        if (bus0.resp_valid !== 1'b1 || bus0.resp_instruction !== 32'h12345678) begin
            errors++;
            $display("FAIL wait0_resp: rv=%b instr=%h required 1 12345678",
                     bus0.resp_valid, bus0.resp_instruction);
        end
        tick();
        checks++;
        if (bus0.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL wait0_done: rr=%b required 1", bus0.req_ready);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.req_valid = 1'b0;  bus.req_address = 32'h0;  bus.resp_ready = 1'b0;
        bus.load_en = 1'b0;    bus.load_address = 8'd0;  bus.load_data = 32'h0;
        bus0.req_valid = 1'b0; bus0.req_address = 32'h0; bus0.resp_ready = 1'b0;
        bus0.load_en = 1'b0;   bus0.load_address = 8'd0; bus0.load_data = 32'h0;
        #2;
        test_reset();
        test_basic();
        test_hold();
        test_error();
        test_reset_mid_wait();
        test_back_to_back();
        test_read_before_write();
        test_wait0();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
